axi_cdc_isolate: RTL and testbench
==================================

// Module: axi_cdc_isolate
// PURPOSE
//  Single-clock AXI4 gate placed directly upstream of the AXI clock-domain crossing, in the source domain.
//  On request, it stops new AW/AR transactions and drains every outstanding burst, then reports isolation.
//  After that the downstream CDC and destination domain can be clock-gated or reset safely.
//  It also caps outstanding transactions so the CDC FIFOs never hold orphaned bursts.
// PARAMETERS
//  aw_chan_t/w_chan_t/b_chan_t/ar_chan_t/r_chan_t  logic  AXI channel payload types
//  axi_req_t   logic  request struct: aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready
//  axi_resp_t  logic  response struct: aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid
//  MaxTxn      8      max outstanding writes and max outstanding reads, each counted separately; must be >= 1
//  CntWidth    $clog2(MaxTxn+1)  derived counter width; do not override
// PORTS
//  clk_i       in   1     clock
//  rst_ni      in   1     asynchronous reset, active low
//  isolate_i   in   1     request isolation; level-sensitive
//  isolated_o  out  1     1 = no transaction outstanding and all channels blocked
//  slv_req_i   in   req   from upstream manager
//  slv_resp_o  out  resp  to upstream manager
//  mst_req_o   out  req   to the CDC
//  mst_resp_i  in   resp  from the CDC
// BEHAVIOUR
//  Counters (CntWidth bits, reset 0):
//   - wr_cnt: +1 on mst AW handshake, -1 on mst B handshake.
//   - w_open: +1 on mst AW handshake, -1 on mst W handshake with w.last.
//   - rd_cnt: +1 on mst AR handshake, -1 on mst R handshake with r.last.
//   - Increment and decrement in the same cycle leave the counter unchanged.
//   - Counters never wrap; overflow is prevented by the stalls below and underflow is an assertion error.
//  FSM states NORMAL (reset), DRAIN, ISOLATED. State is registered.
//   - NORMAL -> DRAIN when isolate_i=1.
//   - DRAIN -> ISOLATED when isolate_i=1 and wr_cnt=w_open=rd_cnt=0 and no AW/AR is held.
//   - DRAIN -> NORMAL when isolate_i=0.
//   - ISOLATED -> NORMAL when isolate_i=0.
//  isolated_o = (state==ISOLATED), registered; reset value 0.
//  It rises 1 cycle after the drain-complete condition is met and falls 1 cycle after isolate_i drops.
//  Payloads (aw, w, b, ar, r) always pass straight through, with zero latency and no registers.
//  AW gate (open => aw_valid/aw_ready connected through; closed => mst aw_valid=0 and slv aw_ready=0):
//   - Open in NORMAL while wr_cnt<MaxTxn.
//   - aw_hold: a 1-bit register set when mst aw_valid=1 and aw_ready=0, cleared on AW handshake.
//   - While aw_hold=1 the gate stays open in every state, so a presented AW is never withdrawn (AXI rule).
//   - Otherwise closed in DRAIN and ISOLATED.
//  AR gate: same rules, using rd_cnt and ar_hold.
//  W gate: open only while w_open>0, in every state.
//   - W data arriving before its AW is stalled (w_ready=0); this is AXI-legal.
//   - ISOLATED implies w_open=0, so W is closed there.
//  B and R always pass through in NORMAL and DRAIN; responses are never dropped.
//  In ISOLATED, mst b_ready/r_ready=0 and slv b_valid/r_valid=0; no response can exist in this state.
//  Reset state: NORMAL, counters 0, holds 0. With slv valids low, all mst valids and slv readies are low.
//  Reset mid-burst clears all state; the destination must be reset in the same window.
//  Assertions: counter underflow; mst B/R valid while the matching counter is 0; aw/ar valid drop without handshake.
// TESTING
//  1) 3 AW (len=3) + 12 W beats, then 3 B -> wr_cnt 0->3->0, w_open 0->3->0, isolated_o stays 0.
//  2) 2 AR outstanding, isolate_i=1 -> new AR stalled, ar_ready=0; after both R last beats, isolated_o=1 exactly 1 cycle later.
//  3) AW valid pending with aw_ready=0 when isolate_i rises -> AW still completes, then drains; isolated_o=1 after its B.
//  4) MaxTxn=2: 3 back-to-back AR with no R -> third AR stalled until the first R last returns.
//  5) W presented 4 cycles before its AW -> w_ready=0 until the AW handshake, then beats flow.
//  6) isolate_i drops in DRAIN and in ISOLATED -> state NORMAL next cycle; a new AW is accepted the following cycle.

Source files
------------

// File: rtl/axi_cdc_isolate.sv
// Default AXI4 channel and bundle types, plus the isolation gate that sits
// in the source domain directly in front of the AXI clock-domain crossing.
// Requested isolation blocks new AW/AR, drains every outstanding burst and
// then reports that the crossing and destination may be gated or reset.
// The gate also caps outstanding transactions so the crossing FIFOs never
// hold orphaned bursts.
package axi_cdc_isolate_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_resp_t;

endpackage

module axi_cdc_isolate #(
  parameter int unsigned MaxTxn   = 8,
  parameter int unsigned CntWidth = $clog2(MaxTxn + 1),
  parameter type aw_chan_t  = axi_cdc_isolate_pkg::aw_chan_t,
  parameter type w_chan_t   = axi_cdc_isolate_pkg::w_chan_t,
  parameter type b_chan_t   = axi_cdc_isolate_pkg::b_chan_t,
  parameter type ar_chan_t  = axi_cdc_isolate_pkg::ar_chan_t,
  parameter type r_chan_t   = axi_cdc_isolate_pkg::r_chan_t,
  parameter type axi_req_t  = axi_cdc_isolate_pkg::axi_req_t,
  parameter type axi_resp_t = axi_cdc_isolate_pkg::axi_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      isolate_i,
  output logic      isolated_o,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i
);

  localparam logic [1:0] NORMAL   = 2'd0;
  localparam logic [1:0] DRAIN    = 2'd1;
  localparam logic [1:0] ISOLATED = 2'd2;

  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxn);

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [CntWidth-1:0] wr_cnt;
  logic [CntWidth-1:0] w_open;
  logic [CntWidth-1:0] rd_cnt;
  logic                aw_hold;
  logic                ar_hold;

  aw_chan_t aw_pl;
  w_chan_t  w_pl;
  b_chan_t  b_pl;
  ar_chan_t ar_pl;
  r_chan_t  r_pl;

  logic aw_gate;
  logic w_gate;
  logic ar_gate;
  logic rsp_gate;
  logic aw_hs;
  logic w_last_hs;
  logic b_hs;
  logic ar_hs;
  logic r_last_hs;
  logic drained;

  // Counters saturate by construction: the AW/AR gates stop increments at
  // MaxTxn, and a simultaneous increment/decrement leaves the count as is.
  function automatic logic [CntWidth-1:0] cnt_step(input logic [CntWidth-1:0] cnt,
                                                   input logic inc,
                                                   input logic dec);
    case ({inc, dec})
      2'b10:   return cnt + CntOne;
      2'b01:   return cnt - CntOne;
      default: return cnt;
    endcase
  endfunction

  // Payloads are never registered; only handshake signals are gated.
  assign aw_pl = slv_req_i.aw;
  assign w_pl  = slv_req_i.w;
  assign ar_pl = slv_req_i.ar;
  assign b_pl  = mst_resp_i.b;
  assign r_pl  = mst_resp_i.r;

  // A held AW/AR keeps its gate open in any state so a presented address is
  // never withdrawn; otherwise new addresses only flow in NORMAL below the cap.
  assign aw_gate  = aw_hold | ((state == NORMAL) & (wr_cnt < CntMax));
  assign ar_gate  = ar_hold | ((state == NORMAL) & (rd_cnt < CntMax));
  // W beats only pass once their AW has been forwarded.
  assign w_gate   = (w_open != '0);
  // Responses are cut only in ISOLATED, where none can be outstanding.
  assign rsp_gate = (state != ISOLATED);

  // Forward the request bundle with gated valids/readies.
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw       = aw_pl;
    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_gate;
    mst_req_o.w        = w_pl;
    mst_req_o.w_valid  = slv_req_i.w_valid & w_gate;
    mst_req_o.b_ready  = slv_req_i.b_ready & rsp_gate;
    mst_req_o.ar       = ar_pl;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_gate;
    mst_req_o.r_ready  = slv_req_i.r_ready & rsp_gate;
  end

  // Return the response bundle with gated valids/readies.
  always_comb begin
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_gate;
    slv_resp_o.w_ready  = mst_resp_i.w_ready & w_gate;
    slv_resp_o.b        = b_pl;
    slv_resp_o.b_valid  = mst_resp_i.b_valid & rsp_gate;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_gate;
    slv_resp_o.r        = r_pl;
    slv_resp_o.r_valid  = mst_resp_i.r_valid & rsp_gate;
  end

  assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign w_last_hs = mst_req_o.w_valid & mst_resp_i.w_ready & w_pl.last;
  assign b_hs      = mst_resp_i.b_valid & mst_req_o.b_ready;
  assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign r_last_hs = mst_resp_i.r_valid & mst_req_o.r_ready & r_pl.last;

  assign drained = (wr_cnt == '0) & (w_open == '0) & (rd_cnt == '0) & ~aw_hold & ~ar_hold;

  // Isolation FSM: dropping isolate_i always returns to NORMAL first.
  always_comb begin
    state_next = state;
    case (state)
      NORMAL: begin
        if (isolate_i) state_next = DRAIN;
      end
      DRAIN: begin
        if (!isolate_i)   state_next = NORMAL;
        else if (drained) state_next = ISOLATED;
      end
      ISOLATED: begin
        if (!isolate_i) state_next = NORMAL;
      end
      default: state_next = NORMAL;
    endcase
  end

  // State register and registered isolation flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= NORMAL;
      isolated_o <= 1'b0;
    end else begin
      state      <= state_next;
      isolated_o <= (state_next == ISOLATED);
    end
  end

  // Outstanding-transaction counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt <= '0;
      w_open <= '0;
      rd_cnt <= '0;
    end else begin
      wr_cnt <= cnt_step(wr_cnt, aw_hs, b_hs);
      w_open <= cnt_step(w_open, aw_hs, w_last_hs);
      rd_cnt <= cnt_step(rd_cnt, ar_hs, r_last_hs);
    end
  end

  // Remember an address that was presented downstream but not yet accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_hold <= 1'b0;
      ar_hold <= 1'b0;
    end else begin
      aw_hold <= mst_req_o.aw_valid & ~mst_resp_i.aw_ready;
      ar_hold <= mst_req_o.ar_valid & ~mst_resp_i.ar_ready;
    end
  end

  a_wr_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(b_hs && !aw_hs && (wr_cnt == '0)));
  a_w_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_last_hs && !aw_hs && (w_open == '0)));
  a_rd_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(r_last_hs && !ar_hs && (rd_cnt == '0)));
  a_b_orphan: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mst_resp_i.b_valid && (wr_cnt == '0)));
  a_r_orphan: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mst_resp_i.r_valid && (rd_cnt == '0)));
  a_aw_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mst_req_o.aw_valid && !mst_resp_i.aw_ready) |=> mst_req_o.aw_valid);
  a_ar_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mst_req_o.ar_valid && !mst_resp_i.ar_ready) |=> mst_req_o.ar_valid);

endmodule

// File: tb/tb_axi_cdc_isolate.sv
// Scoreboard bench for axi_cdc_isolate. Stimulus pushes expected handshakes
// (payload plus the cycle they must complete in) into per-channel queues; a
// negedge monitor pops and compares each handshake the DUT presents.
module tb_axi_cdc_isolate;
  import axi_cdc_isolate_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      isolate;
  logic      isolated;
  axi_req_t  slv_req, mst_req;
  axi_resp_t slv_resp, mst_resp;

  logic      isolated2;
  axi_req_t  slv_req2, mst_req2;
  axi_resp_t slv_resp2, mst_resp2;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic prev_iso = 1'b0;

  exp_t q_aw[$], q_w[$], q_ar[$], q_b[$], q_r[$], q_iso[$], q_ar2[$];

  axi_cdc_isolate #(.MaxTxn(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .isolate_i(isolate), .isolated_o(isolated),
    .slv_req_i(slv_req), .slv_resp_o(slv_resp),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp));

  axi_cdc_isolate #(.MaxTxn(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .isolate_i(1'b0), .isolated_o(isolated2),
    .slv_req_i(slv_req2), .slv_resp_o(slv_resp2),
    .mst_req_o(mst_req2), .mst_resp_i(mst_resp2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int ch, input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    case (ch)
      0: q_aw.push_back(e);
      1: q_w.push_back(e);
      2: q_ar.push_back(e);
      3: q_b.push_back(e);
      4: q_r.push_back(e);
      5: q_iso.push_back(e);
      default: q_ar2.push_back(e);
    endcase
  endtask

  task automatic observe(input int ch, input string nm, input logic [31:0] d);
    exp_t e;
    bit got = 1'b0;
    case (ch)
      0: if (q_aw.size() != 0)  begin e = q_aw.pop_front();  got = 1'b1; end
      1: if (q_w.size() != 0)   begin e = q_w.pop_front();   got = 1'b1; end
      2: if (q_ar.size() != 0)  begin e = q_ar.pop_front();  got = 1'b1; end
      3: if (q_b.size() != 0)   begin e = q_b.pop_front();   got = 1'b1; end
      4: if (q_r.size() != 0)   begin e = q_r.pop_front();   got = 1'b1; end
      5: if (q_iso.size() != 0) begin e = q_iso.pop_front(); got = 1'b1; end
      default: if (q_ar2.size() != 0) begin e = q_ar2.pop_front(); got = 1'b1; end
    endcase
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected actual=%0h at cycle %0d required=none", nm, d, cyc);
    end else begin
      check({nm, "_data"}, d, e.data);
      check({nm, "_cycle"}, cyc, e.cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every handshake and every isolated_o edge must be expected.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mst_req.aw_valid && mst_resp.aw_ready) begin
        observe(0, "aw", mst_req.aw.addr);
        check("aw_slv_ready", slv_resp.aw_ready, 1);
      end
      if (mst_req.w_valid && mst_resp.w_ready) begin
        observe(1, "w", mst_req.w.data);
        check("w_slv_ready", slv_resp.w_ready, 1);
      end
      if (mst_req.ar_valid && mst_resp.ar_ready) begin
        observe(2, "ar", mst_req.ar.addr);
        check("ar_slv_ready", slv_resp.ar_ready, 1);
      end
      if (slv_resp.b_valid && slv_req.b_ready) begin
        observe(3, "b", 32'(slv_resp.b.id));
        check("b_mst_ready", mst_req.b_ready, 1);
      end
      if (slv_resp.r_valid && slv_req.r_ready) begin
        observe(4, "r", slv_resp.r.data);
        check("r_mst_ready", mst_req.r_ready, 1);
      end
      if (isolated !== prev_iso) observe(5, "iso", 32'(isolated));
      if (mst_req2.ar_valid && mst_resp2.ar_ready) observe(6, "ar2", mst_req2.ar.addr);
      if (isolated2 !== 1'b0) observe(6, "iso2", 32'(isolated2));
    end
    prev_iso <= isolated;
  end

  initial begin
    int c;
    slv_req   = '0;
    mst_resp  = '0;
    slv_req2  = '0;
    mst_resp2 = '0;
    isolate   = 1'b0;
    rst_n     = 1'b0;
    tick(3);

    // Reset state: nothing forwarded, W closed even with a ready subordinate.
    mst_resp.w_ready = 1'b1;
    #1;
    check("rst_isolated", isolated, 0);
    check("rst_mst_aw_valid", mst_req.aw_valid, 0);
    check("rst_mst_ar_valid", mst_req.ar_valid, 0);
    check("rst_mst_w_valid", mst_req.w_valid, 0);
    check("rst_slv_aw_ready", slv_resp.aw_ready, 0);
    check("rst_slv_w_ready", slv_resp.w_ready, 0);
    check("rst_slv_b_valid", slv_resp.b_valid, 0);
    rst_n = 1'b1;
    tick(2);

    // Test 1: 3 AW (len 3), 12 W beats, 3 B.
    mst_resp.aw_ready = 1'b1;
    mst_resp.ar_ready = 1'b1;
    slv_req.b_ready   = 1'b1;
    slv_req.r_ready   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slv_req.aw_valid = 1'b1;
      slv_req.aw.addr  = 32'h1000 + 32'(i * 16);
      slv_req.aw.len   = 8'd3;
      slv_req.aw.id    = 4'(i);
      push(0, slv_req.aw.addr, cyc);
      tick();
    end
    slv_req.aw_valid = 1'b0;
    check("t1_wr_cnt_full", dut.wr_cnt, 3);
    check("t1_w_open_full", dut.w_open, 3);
    for (int i = 0; i < 12; i++) begin
      slv_req.w_valid = 1'b1;
      slv_req.w.data  = 32'hD000 + 32'(i);
      slv_req.w.last  = (i % 4 == 3);
      push(1, slv_req.w.data, cyc);
      tick();
    end
    slv_req.w_valid = 1'b0;
    check("t1_w_open_done", dut.w_open, 0);
    check("t1_wr_cnt_wait_b", dut.wr_cnt, 3);
    for (int i = 0; i < 3; i++) begin
      mst_resp.b_valid = 1'b1;
      mst_resp.b.id    = 4'(i);
      push(3, 32'(i), cyc);
      tick();
    end
    mst_resp.b_valid = 1'b0;
    check("t1_wr_cnt_empty", dut.wr_cnt, 0);
    tick(2);

    // Test 2: 2 AR outstanding, isolate, new AR stalled until de-isolation.
    c = cyc;
    for (int i = 0; i < 2; i++) begin
      slv_req.ar_valid = 1'b1;
      slv_req.ar.addr  = 32'h2000 + 32'(i * 16);
      slv_req.ar.len   = 8'd0;
      push(2, slv_req.ar.addr, cyc);
      tick();
    end
    slv_req.ar_valid = 1'b0;
    isolate = 1'b1;
    tick();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.addr  = 32'h2020;
    #1;
    check("t2_drain_ar_ready", slv_resp.ar_ready, 0);
    check("t2_drain_ar_valid", mst_req.ar_valid, 0);
    tick();
    push(5, 32'd1, c + 7);
    for (int i = 0; i < 2; i++) begin
      mst_resp.r_valid = 1'b1;
      mst_resp.r.data  = 32'hA000 + 32'(i);
      mst_resp.r.last  = 1'b1;
      push(4, mst_resp.r.data, cyc);
      tick();
    end
    mst_resp.r_valid = 1'b0;
    tick();
    check("t2_iso_ar_ready", slv_resp.ar_ready, 0);
    isolate = 1'b0;
    push(5, 32'd0, cyc + 1);
    push(2, 32'h2020, cyc + 1);
    tick(2);
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b1;
    mst_resp.r.data  = 32'hA002;
    push(4, 32'hA002, cyc);
    tick();
    mst_resp.r_valid = 1'b0;
    tick(2);

    // Test 3: AW pending with aw_ready=0 as isolation is requested.
    c = cyc;
    mst_resp.aw_ready = 1'b0;
    slv_req.aw_valid  = 1'b1;
    slv_req.aw.addr   = 32'h3000;
    slv_req.aw.len    = 8'd0;
    isolate           = 1'b1;
    push(0, 32'h3000, c + 2);
    push(5, 32'd1, c + 7);
    tick();
    check("t3_aw_held_valid", mst_req.aw_valid, 1);
    tick();
    mst_resp.aw_ready = 1'b1;
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b1;
    slv_req.w.data   = 32'h3333;
    slv_req.w.last   = 1'b1;
    push(1, 32'h3333, cyc);
    tick();
    slv_req.w_valid = 1'b0;
    tick();
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = 4'd5;
    push(3, 32'd5, cyc);
    tick();
    mst_resp.b_valid = 1'b0;
    tick();
    // Test 6a: leave ISOLATED; a new AW is accepted the following cycle.
    isolate = 1'b0;
    push(5, 32'd0, cyc + 1);
    tick();
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 32'h3100;
    push(0, 32'h3100, cyc);
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b1;
    slv_req.w.data   = 32'h3131;
    slv_req.w.last   = 1'b1;
    push(1, 32'h3131, cyc);
    tick();
    slv_req.w_valid  = 1'b0;
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = 4'd6;
    push(3, 32'd6, cyc);
    tick();
    mst_resp.b_valid = 1'b0;
    tick(2);

    // Test 6b: isolate dropped while still draining.
    c = cyc;
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 32'h4000;
    slv_req.aw.len   = 8'd1;
    push(0, 32'h4000, c);
    tick();
    slv_req.aw_valid = 1'b0;
    isolate = 1'b1;
    tick();
    isolate          = 1'b0;
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 32'h4100;
    #1;
    check("t6_drain_aw_ready", slv_resp.aw_ready, 0);
    push(0, 32'h4100, c + 3);
    tick(2);
    slv_req.aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slv_req.w_valid = 1'b1;
      slv_req.w.data  = 32'h4400 + 32'(i);
      slv_req.w.last  = (i % 2 == 1);
      push(1, slv_req.w.data, cyc);
      tick();
    end
    slv_req.w_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mst_resp.b_valid = 1'b1;
      mst_resp.b.id    = 4'(8 + i);
      push(3, 32'(8 + i), cyc);
      tick();
    end
    mst_resp.b_valid = 1'b0;
    tick(2);

    // Test 5: W presented 4 cycles before its AW.
    c = cyc;
    slv_req.w_valid = 1'b1;
    slv_req.w.data  = 32'h5000;
    slv_req.w.last  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t5_early_w_ready", slv_resp.w_ready, 0);
      check("t5_early_w_valid", mst_req.w_valid, 0);
      tick();
    end
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 32'h5500;
    slv_req.aw.len   = 8'd1;
    push(0, 32'h5500, c + 4);
    push(1, 32'h5000, c + 5);
    #1;
    check("t5_aw_cycle_w_ready", slv_resp.w_ready, 0);
    tick();
    slv_req.aw_valid = 1'b0;
    tick();
    slv_req.w.data = 32'h5001;
    slv_req.w.last = 1'b1;
    push(1, 32'h5001, cyc);
    tick();
    slv_req.w_valid  = 1'b0;
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = 4'd7;
    push(3, 32'd7, cyc);
    tick();
    mst_resp.b_valid = 1'b0;
    tick(2);

    // Test 4: MaxTxn=2 instance, third AR waits for the first R last.
    c = cyc;
    mst_resp2.ar_ready = 1'b1;
    slv_req2.r_ready   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      slv_req2.ar_valid = 1'b1;
      slv_req2.ar.addr  = 32'h6000 + 32'(i * 16);
      push(6, slv_req2.ar.addr, cyc);
      tick();
    end
    slv_req2.ar.addr = 32'h6020;
    push(6, 32'h6020, c + 4);
    #1;
    check("t4_cap_ar_ready", slv_resp2.ar_ready, 0);
    tick();
    check("t4_cap_ar_ready2", slv_resp2.ar_ready, 0);
    check("t4_cap_ar_valid", mst_req2.ar_valid, 0);
    mst_resp2.r_valid = 1'b1;
    mst_resp2.r.last  = 1'b1;
    mst_resp2.r.data  = 32'h6006;
    tick();
    mst_resp2.r_valid = 1'b0;
    tick();
    slv_req2.ar_valid = 1'b0;
    mst_resp2.r_valid = 1'b1;
    tick(2);
    mst_resp2.r_valid = 1'b0;
    check("t4_rd_cnt_empty", dut2.rd_cnt, 0);
    tick(5);

    check("end_q_aw", q_aw.size(), 0);
    check("end_q_w", q_w.size(), 0);
    check("end_q_ar", q_ar.size(), 0);
    check("end_q_b", q_b.size(), 0);
    check("end_q_r", q_r.size(), 0);
    check("end_q_iso", q_iso.size(), 0);
    check("end_q_ar2", q_ar2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
